fifo_read_prefetch: RTL and testbench

//  Read-side output stage of the async FIFO, read_clock domain, directly downstream of empty_gen and the RAM read port.

---
 rtl/fifo_read_prefetch.sv | 97 +++++++++
 tb/tb_fifo_read_prefetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_prefetch.sv
// Read-side output stage of the async FIFO: converts pointer/empty handshaking into a
// first-word-fall-through valid/ready stream through a 2-entry prefetch buffer.
module fifo_read_prefetch #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   read_clock,
    input  logic                   reset_n,
    input  logic                   empty_flag,
    input  logic [WIDTH-1:0]       ram_read_data,
    input  logic                   out_ready,
    output logic                   read_enable,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [COUNT_WIDTH-1:0] read_word_count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [WIDTH-1:0]       head_q, head_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    logic       pop;
    logic       push;
    logic [2:0] occupancy;

    assign out_valid       = (state_q != EMPTY);
    assign out_data        = head_q;
    assign read_word_count = word_cnt_q;

    assign pop  = out_valid & out_ready;
    assign push = pending_q;

    // Words buffered plus in flight, after this cycle's pop; never request a third.
    assign occupancy   = {1'b0, state_q} + {2'b0, pending_q} - {2'b0, pop};
    assign read_enable = reset_n & ~empty_flag & (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        b_d        = b_q;
        pending_d  = read_enable;
        word_cnt_d = word_cnt_q + COUNT_WIDTH'(pop);
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = ram_read_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = TWO;
                    b_d     = ram_read_data;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    head_d = ram_read_data;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d = b_q;
                    if (push) b_d = ram_read_data;
                    else      state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge read_clock) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            pending_q  <= 1'b0;
            head_q     <= '0;
            b_q        <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            head_q     <= head_d;
            b_q        <= b_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Flow control must keep the two buffer slots from ever being oversubscribed.
    a_occupancy: assert property (@(posedge read_clock) disable iff (!reset_n)
        ({1'b0, state_q} + {2'b0, pending_q}) <= 3'd2);
    a_no_overflow: assert property (@(posedge read_clock) disable iff (!reset_n)
        !(state_q == TWO && push && !pop));

endmodule

// File: tb/tb_fifo_read_prefetch.sv
// Bench for fifo_read_prefetch: RAM/source model feeding a scoreboard, a cycle table for
// the single-word stall case, and hand-written sequences for backpressure, reset and wrap.
module tb_fifo_read_prefetch;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          read_clock = 1'b0;
    logic          reset_n;
    logic          empty_flag;
    logic [W-1:0]  ram_read_data;
    logic          out_ready;
    logic          read_enable;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] read_word_count;

    always #5 read_clock = ~read_clock;

    fifo_read_prefetch #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .read_clock      (read_clock),
        .reset_n         (reset_n),
        .empty_flag      (empty_flag),
        .ram_read_data   (ram_read_data),
        .out_ready       (out_ready),
        .read_enable     (read_enable),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .read_word_count (read_word_count)
    );

    typedef struct {
        logic         rdy;
        logic         re;
        logic         valid;
        logic [W-1:0] data;
    } vec_t;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  src[$];
    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] cnt_model;
    logic          s_re, s_valid;
    logic [W-1:0]  s_data;
    logic          prev_stall;
    logic [W-1:0]  prev_data;
    int            delivered;
    int            re_pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // One read_clock cycle: drive ready, sample at negedge, then model the RAM port.
    task automatic cyc(input logic rdy);
        logic [W-1:0] w;
        out_ready = rdy;
        @(negedge read_clock);
        s_re    = read_enable;
        s_valid = out_valid;
        s_data  = out_data;
        if (reset_n) begin
            check("word_count", 32'(read_word_count), 32'(cnt_model));
            if (prev_stall) begin
                check("stall_valid", 32'(s_valid), 32'd1);
                check("stall_data", 32'(s_data), 32'(prev_data));
            end
            if (s_valid && rdy) begin
                if (exp_q.size() == 0) fail("unexpected_word");
                else begin
                    w = exp_q.pop_front();
                    check("out_data", 32'(s_data), 32'(w));
                end
                cnt_model++;
                delivered++;
            end
            prev_stall = s_valid && !rdy;
            prev_data  = s_data;
        end
        if (s_re) re_pulses++;
        @(posedge read_clock);
        #1;
        if (!reset_n) begin
            exp_q.delete();
            src.delete();
            cnt_model  = '0;
            prev_stall = 1'b0;
        end else begin
            if (s_re) begin
                if (src.size() == 0) fail("overread");
                else begin
                    w = src.pop_front();
                    ram_read_data = w;
                    exp_q.push_back(w);
                end
            end else begin
                ram_read_data = 8'($urandom());
            end
            empty_flag = (src.size() == 0);
        end
    endtask

    task automatic load(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) src.push_back(base + 8'(i));
        empty_flag = (src.size() == 0);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        cyc(1'b0);
        reset_n    = 1'b1;
        empty_flag = 1'b1;
        delivered  = 0;
        re_pulses  = 0;
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 2; i < 7; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 8'hA5};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00};

        reset_n       = 1'b0;
        empty_flag    = 1'b0;
        out_ready     = 1'b0;
        ram_read_data = '0;
        cnt_model     = '0;
        prev_stall    = 1'b0;
        delivered     = 0;
        re_pulses     = 0;
        @(posedge read_clock);
        #1;

        // Reset held with a non-empty FIFO: nothing may be requested or presented.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            check("rst_read_enable", 32'(s_re), 32'd0);
            check("rst_out_valid", 32'(s_valid), 32'd0);
            check("rst_out_data", 32'(s_data), 32'd0);
            check("rst_word_count", 32'(read_word_count), 32'd0);
        end

        // Single word with the sink stalled, then released.
        reset_n    = 1'b1;
        empty_flag = 1'b1;
        load(1, 8'hA5);
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].rdy);
            check($sformatf("tbl%0d_read_enable", i), 32'(s_re), 32'(tbl[i].re));
            check($sformatf("tbl%0d_out_valid", i), 32'(s_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) check($sformatf("tbl%0d_out_data", i), 32'(s_data), 32'(tbl[i].data));
        end

        // Streaming at full rate: after the first word, no bubbles.
        reset_pulse();
        load(8, 8'h10);
        begin
            logic started = 1'b0;
            for (int i = 0; i < 30 && delivered < 8; i++) begin
                cyc(1'b1);
                if (started) check("stream_no_gap", 32'(s_valid), 32'd1);
                if (s_valid) started = 1'b1;
            end
        end
        check("stream_delivered", 32'(delivered), 32'd8);
        cyc(1'b0);
        check("stream_count8", 32'(read_word_count), 32'd8);

        // Backpressure: only two requests while stalled, then drain with toggling ready.
        reset_pulse();
        load(8, 8'h10);
        for (int i = 0; i < 8; i++) cyc(1'b0);
        check("bp_pulses", 32'(re_pulses), 32'd2);
        check("bp_valid", 32'(s_valid), 32'd1);
        check("bp_head", 32'(s_data), 32'h10);
        for (int i = 0; i < 60 && delivered < 8; i++) cyc(i % 2 == 0);
        check("bp_delivered", 32'(delivered), 32'd8);
        check("bp_leftover", 32'(exp_q.size()), 32'd0);

        // Reset while a RAM word is in flight: that word must never appear.
        reset_pulse();
        load(1, 8'h55);
        cyc(1'b0);
        check("mid_rst_req", 32'(s_re), 32'd1);
        reset_n = 1'b0;
        cyc(1'b0);
        check("mid_rst_re_low", 32'(s_re), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            check("mid_rst_valid", 32'(s_valid), 32'd0);
        end

        // Delivered-word counter wraps modulo 2^CW.
        reset_pulse();
        load(17, 8'h80);
        for (int i = 0; i < 60 && delivered < 17; i++) cyc(1'b1);
        check("wrap_delivered", 32'(delivered), 32'd17);
        cyc(1'b0);
        check("wrap_count", 32'(read_word_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
